// File: rtl/byteblast_pkg.sv
// byteblast_pkg
// Shared definitions for the byteblast fetch path: default widths, the
// opcode bit that flags a two-byte instruction, and the ifetch state type.
package byteblast_pkg;

    localparam int BB_ADDR_W      = 8;
    localparam int BB_DATA_W      = 8;
    localparam int BB_OPERAND_BIT = 7;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        OP_REQ  = 2'd1,
        ARG_REQ = 2'd2,
        DONE    = 2'd3
    } ifetch_state_e;

endpackage

// File: rtl/pc_8bit.sv
// pc_8bit
// Program counter register with asynchronous active-low reset.
// load_i takes priority and loads load_addr_i; inc_i advances by one,
// wrapping modulo 2^ADDR_W.
//   clk          in   system clock, rising edge
//   rst_n        in   async active-low reset, loads RESET_PC
//   load_i       in   load load_addr_i on the next edge
//   load_addr_i  in   load target
//   inc_i        in   increment on the next edge
//   pc_o         out  current program counter
module pc_8bit #(
    parameter int                ADDR_W   = 8,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_i,
    input  logic [ADDR_W-1:0] load_addr_i,
    input  logic              inc_i,
    output logic [ADDR_W-1:0] pc_o
);

    logic [ADDR_W-1:0] pc_q;
    logic [ADDR_W-1:0] pc_d;

    always_comb begin
        pc_d = pc_q;
        if (load_i) begin
            pc_d = load_addr_i;
        end else if (inc_i) begin
            pc_d = pc_q + {{(ADDR_W-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc_o = pc_q;

endmodule

// File: rtl/ifetch_8bit.sv
// ifetch_8bit
// Instruction fetch unit sitting behind the fde_8bit phase sequencer.
// Reads an opcode (and an operand when the opcode flags one) from program
// memory over a req/ack handshake and stalls the sequencer in its fetch
// phase until the instruction register is complete.
//   clk, rst_n            clock and async active-low reset
//   fetch/decode/execute  phase levels from fde_8bit (decode unused here)
//   jump_en, jump_addr    branch request, honoured in IDLE during execute
//   mem_req/mem_addr      program-memory read request and address (= pc)
//   mem_ack/mem_rdata     read completion with same-cycle data
//   fde_enable            low stalls the sequencer
//   pc                    program counter
//   ir_opcode/ir_operand  instruction register
//   ir_valid              instruction register holds a complete instruction
//
// state   | meaning
// IDLE    | waiting for the fetch phase; jumps accepted here
// OP_REQ  | requesting the opcode byte at pc
// ARG_REQ | requesting the operand byte at pc
// DONE    | instruction complete; release the sequencer until fetch drops
module ifetch_8bit
    import byteblast_pkg::*;
#(
    parameter int                ADDR_W      = BB_ADDR_W,
    parameter int                DATA_W      = BB_DATA_W,
    parameter logic [ADDR_W-1:0] RESET_PC    = '0,
    parameter int                OPERAND_BIT = BB_OPERAND_BIT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              fetch,
    input  logic              decode,
    input  logic              execute,
    input  logic              jump_en,
    input  logic [ADDR_W-1:0] jump_addr,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              fde_enable,
    output logic [ADDR_W-1:0] pc,
    output logic [DATA_W-1:0] ir_opcode,
    output logic [DATA_W-1:0] ir_operand,
    output logic              ir_valid
);

    ifetch_state_e     state_q;
    logic [DATA_W-1:0] ir_opcode_q;
    logic [DATA_W-1:0] ir_operand_q;
    logic              ir_valid_q;
    logic              mem_req_q;
    logic              fetched_q;

    logic              pc_load;
    logic              pc_inc;
    logic              xfer;
    logic              unused_decode;

    assign unused_decode = decode;

    // mem_req_q is only ever high in OP_REQ/ARG_REQ, so gating the ack with
    // it both drops stray acks and marks exactly one transfer per ack.
    assign xfer    = mem_req_q && mem_ack;
    assign pc_inc  = xfer;
    // fetch takes precedence over a (malformed) simultaneous execute phase.
    assign pc_load = (state_q == IDLE) && !fetch && execute && jump_en;

    pc_8bit #(
        .ADDR_W   (ADDR_W),
        .RESET_PC (RESET_PC)
    ) u_pc (
        .clk         (clk),
        .rst_n       (rst_n),
        .load_i      (pc_load),
        .load_addr_i (jump_addr),
        .inc_i       (pc_inc),
        .pc_o        (pc)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            ir_opcode_q  <= '0;
            ir_operand_q <= '0;
            ir_valid_q   <= 1'b0;
            mem_req_q    <= 1'b0;
            fetched_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (fetch) begin
                        state_q    <= OP_REQ;
                        ir_valid_q <= 1'b0;
                        mem_req_q  <= 1'b1;
                    end
                end
                OP_REQ: begin
                    if (xfer) begin
                        ir_opcode_q <= mem_rdata;
                        if (mem_rdata[OPERAND_BIT]) begin
                            // back-to-back: request stays high into ARG_REQ
                            state_q <= ARG_REQ;
                        end else begin
                            state_q    <= DONE;
                            mem_req_q  <= 1'b0;
                            fetched_q  <= 1'b1;
                            ir_valid_q <= 1'b1;
                        end
                    end
                end
                ARG_REQ: begin
                    if (xfer) begin
                        ir_operand_q <= mem_rdata;
                        state_q      <= DONE;
                        mem_req_q    <= 1'b0;
                        fetched_q    <= 1'b1;
                        ir_valid_q   <= 1'b1;
                    end
                end
                DONE: begin
                    if (!fetch) begin
                        state_q   <= IDLE;
                        fetched_q <= 1'b0;
                    end
                end
                default: begin
                    state_q   <= IDLE;
                    mem_req_q <= 1'b0;
                    fetched_q <= 1'b0;
                end
            endcase
        end
    end

    assign mem_req    = mem_req_q;
    assign mem_addr   = pc;
    assign fde_enable = !fetch || fetched_q;
    assign ir_opcode  = ir_opcode_q;
    assign ir_operand = ir_operand_q;
    assign ir_valid   = ir_valid_q;

endmodule

// File: tb/tb_ifetch_8bit.sv
module tb_ifetch_8bit;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       fetch, decode, execute, jump_en;
    logic [7:0] jump_addr;
    logic       mem_req;
    logic [7:0] mem_addr;
    logic       mem_ack;
    logic [7:0] mem_rdata;
    logic       fde_enable;
    logic [7:0] pc;
    logic [7:0] ir_opcode, ir_operand;
    logic       ir_valid;

    int total = 0;
    int bad   = 0;

    logic [7:0] mem [256];
    logic [7:0] model_pc;

    typedef struct {
        logic [7:0] op;
        logic [7:0] arg;
        logic [7:0] pc;
    } exp_t;

    typedef struct {
        int         w;
        logic [7:0] op;
        logic [7:0] arg;
        logic [7:0] pc;
        int         cyc;
    } vec_t;

    exp_t       exp_q [$];
    logic [7:0] addr_q [$];
    vec_t       vecs [4];

    always #5 clk = ~clk;

    ifetch_8bit dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .fetch      (fetch),
        .decode     (decode),
        .execute    (execute),
        .jump_en    (jump_en),
        .jump_addr  (jump_addr),
        .mem_req    (mem_req),
        .mem_addr   (mem_addr),
        .mem_ack    (mem_ack),
        .mem_rdata  (mem_rdata),
        .fde_enable (fde_enable),
        .pc         (pc),
        .ir_opcode  (ir_opcode),
        .ir_operand (ir_operand),
        .ir_valid   (ir_valid)
    );

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Called one step after a rising edge. Drives a full fetch phase, serving
    // memory with w wait cycles per read, then drops fetch for one cycle.
    task automatic run_fetch(input string nm, input int w, input logic [7:0] e_op,
                             input logic [7:0] e_arg, input logic [7:0] e_pc, input int e_cyc);
        exp_t e;
        exp_t got;
        int   ncyc;
        int   wcnt;
        e.op  = e_op;
        e.arg = e_arg;
        e.pc  = e_pc;
        exp_q.push_back(e);
        addr_q.push_back(model_pc);
        if (e_op[7]) addr_q.push_back(model_pc + 8'd1);
        ncyc    = 0;
        wcnt    = 0;
        mem_ack = 1'b0;
        fetch   = 1'b1;
        while (ncyc < 60) begin
            @(posedge clk);
            ncyc++;
            #1;
            mem_ack = 1'b0;
            if (fde_enable) break;
            if (mem_req) begin
                if (addr_q.size() > 0) check({nm, "_addr"}, mem_addr, addr_q[0]);
                else check({nm, "_extra_req"}, mem_req, 0);
                if (wcnt == w) begin
                    mem_ack   = 1'b1;
                    mem_rdata = mem[mem_addr];
                    if (addr_q.size() > 0) void'(addr_q.pop_front());
                    wcnt = 0;
                end else begin
                    wcnt++;
                end
            end
        end
        check({nm, "_done"}, fde_enable, 1);
        check({nm, "_cycles"}, ncyc, e_cyc);
        got = exp_q.pop_front();
        check({nm, "_opcode"}, ir_opcode, got.op);
        check({nm, "_operand"}, ir_operand, got.arg);
        check({nm, "_pc"}, pc, got.pc);
        check({nm, "_valid"}, ir_valid, 1);
        check({nm, "_reads_left"}, addr_q.size(), 0);
        addr_q.delete();
        fetch = 1'b0;
        @(posedge clk);
        #1;
        check({nm, "_idle_enable"}, fde_enable, 1);
        check({nm, "_valid_held"}, ir_valid, 1);
        check({nm, "_req_low"}, mem_req, 0);
        model_pc = e_pc;
    endtask

    task automatic do_jump(input logic [7:0] a);
        execute   = 1'b1;
        jump_en   = 1'b1;
        jump_addr = a;
        @(posedge clk);
        #1;
        execute = 1'b0;
        jump_en = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        mem[8'h00] = 8'h12;
        mem[8'h01] = 8'h85;
        mem[8'h02] = 8'h3C;
        mem[8'h03] = 8'h05;
        mem[8'h04] = 8'hC1;
        mem[8'h05] = 8'hAA;
        mem[8'h40] = 8'h22;
        mem[8'h41] = 8'h33;
        mem[8'hFF] = 8'h90;

        //          wait  op     arg    pc     cycles
        vecs[0] = '{2, 8'h12, 8'h00, 8'h01, 4};
        vecs[1] = '{0, 8'h85, 8'h3C, 8'h03, 3};
        vecs[2] = '{1, 8'h05, 8'h3C, 8'h04, 3};
        vecs[3] = '{3, 8'hC1, 8'hAA, 8'h06, 9};

        rst_n = 1'b0; fetch = 1'b0; decode = 1'b0; execute = 1'b0;
        jump_en = 1'b0; jump_addr = 8'h00; mem_ack = 1'b0; mem_rdata = 8'h00;
        model_pc = 8'h00;
        #12;
        check("rst_pc", pc, 8'h00);
        check("rst_req", mem_req, 0);
        check("rst_valid", ir_valid, 0);
        check("rst_opcode", ir_opcode, 8'h00);
        check("rst_operand", ir_operand, 8'h00);
        check("rst_enable", fde_enable, 1);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 4; i++) begin
            run_fetch($sformatf("vec%0d", i), vecs[i].w, vecs[i].op, vecs[i].arg,
                      vecs[i].pc, vecs[i].cyc);
        end

        do_jump(8'h40);
        check("jump_pc", pc, 8'h40);
        execute   = 1'b0;
        jump_en   = 1'b1;
        jump_addr = 8'h77;
        @(posedge clk);
        #1;
        check("nojump_pc", pc, 8'h40);
        jump_en = 1'b0;
        model_pc = 8'h40;
        run_fetch("after_jump", 0, 8'h22, 8'hAA, 8'h41, 2);

        execute = 1'b1; jump_en = 1'b1; jump_addr = 8'h99;
        run_fetch("fetch_wins", 0, 8'h33, 8'hAA, 8'h42, 2);
        execute = 1'b0; jump_en = 1'b0;

        mem[8'h00] = 8'h07;
        do_jump(8'hFF);
        check("wrap_jump_pc", pc, 8'hFF);
        model_pc = 8'hFF;
        run_fetch("wrap", 0, 8'h90, 8'h07, 8'h01, 3);

        fetch = 1'b1;
        @(posedge clk);
        #1;
        check("mid_op_req", mem_req, 1);
        check("mid_op_addr", mem_addr, 8'h01);
        mem_ack = 1'b1;
        mem_rdata = mem[8'h01];
        @(posedge clk);
        #1;
        mem_ack = 1'b0;
        check("mid_arg_req", mem_req, 1);
        check("mid_arg_addr", mem_addr, 8'h02);
        check("mid_opcode", ir_opcode, 8'h85);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_req", mem_req, 0);
        check("mid_rst_pc", pc, 8'h00);
        check("mid_rst_valid", ir_valid, 0);
        check("mid_rst_enable", fde_enable, 0);
        check("mid_rst_opcode", ir_opcode, 8'h00);
        fetch = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        mem_ack = 1'b1;
        mem_rdata = 8'hEE;
        @(posedge clk);
        #1;
        mem_ack = 1'b0;
        check("late_ack_opcode", ir_opcode, 8'h00);
        check("late_ack_operand", ir_operand, 8'h00);
        check("late_ack_valid", ir_valid, 0);
        check("late_ack_pc", pc, 8'h00);
        check("late_ack_req", mem_req, 0);

        rst_n = 1'b0;
        fetch = 1'b1;
        #1;
        check("rst_fetch_enable", fde_enable, 0);
        check("rst_fetch_req", mem_req, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("rel_op_req", mem_req, 1);
        check("rel_op_addr", mem_addr, 8'h00);
        fetch = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ifetch_8bit.md
Name: ifetch_8bit

Overview:
Instruction fetch unit directly downstream of the fde_8bit phase sequencer. Consumes its fetch/decode/execute phase levels and owns the program counter. Reads one or two instruction bytes from program memory over a req/ack handshake and latches them into the instruction register. Holds the sequencer in the fetch phase through its enable input until the instruction is complete.

Parameters:
ADDR_W, 8, program-memory address width and PC width
DATA_W, 8, instruction byte width
RESET_PC, 0, PC value loaded on reset
OPERAND_BIT, 7, opcode bit that, when 1, marks a two-byte instruction (opcode + operand)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  reset, asynchronous, active-low
fetch  in  1  fetch-phase level from fde_8bit
decode  in  1  decode-phase level from fde_8bit (observed only; no effect in this block)
execute  in  1  execute-phase level from fde_8bit
jump_en  in  1  branch request from the execute stage, honoured only while execute=1
jump_addr  in  ADDR_W  branch target
mem_req  out  1  program-memory read request
mem_addr  out  ADDR_W  read address; always equals pc
mem_ack  in  1  read complete; mem_rdata valid in the same cycle
mem_rdata  in  DATA_W  read data
fde_enable  out  1  enable to fde_8bit; low stalls the sequencer
pc  out  ADDR_W  program counter
ir_opcode  out  DATA_W  latched opcode byte
ir_operand  out  DATA_W  latched operand byte
ir_valid  out  1  instruction register holds a complete instruction

Behaviour:
- Reset (rst_n=0, asynchronous): state=IDLE, pc=RESET_PC, ir_opcode=0, ir_operand=0, ir_valid=0, mem_req=0, fetched=0. All take effect immediately, without a clock edge.
- fde_enable = !fetch || fetched (combinational). The sequencer therefore cannot leave the fetch phase until the fetch completes. Outside the fetch phase it is never stalled.
- FSM states and transitions:
  - IDLE: if fetch=1, go to OP_REQ and clear ir_valid.
  - OP_REQ: mem_req=1.
    - On a clock edge with mem_ack=1: ir_opcode<=mem_rdata, pc<=pc+1.
    - Then go to ARG_REQ if mem_rdata[OPERAND_BIT]=1, else go to DONE.
  - ARG_REQ: mem_req=1. On a clock edge with mem_ack=1: ir_operand<=mem_rdata, pc<=pc+1, go to DONE.
  - DONE: fetched=1, ir_valid=1. Stay until fetch=0, then go to IDLE and clear fetched. ir_valid stays 1 until the next OP_REQ entry.
- Handshake:
  - mem_req is a decoded state output and is held until ack.
  - Ack latency is unbounded; a zero-wait ack (ack in the first req cycle) is legal.
  - mem_ack while mem_req=0 is ignored.
  - One transfer per ack; back-to-back reads are possible (OP_REQ -> ARG_REQ with no idle cycle between them).
- ir_operand is not modified by one-byte instructions (retains its previous value).
- PC arithmetic is modulo 2^ADDR_W: 0xFF+1 wraps to 0x00, including between the opcode and operand reads.
- Jump:
  - In IDLE with execute=1 and jump_en=1, pc<=jump_addr at the clock edge.
  - jump_en is ignored when execute=0 or when state!=IDLE.
  - A jump has priority over nothing else; increment and jump are never simultaneous, by construction.
- Simultaneous fetch and execute (illegal from fde_8bit): fetch wins, jump is ignored.
- Reset mid-operation:
  - The pending request is abandoned and mem_req drops asynchronously.
  - A late mem_ack after reset release is ignored because the FSM is in IDLE.
- Latency: a one-byte fetch with zero-wait memory takes 1 cycle in OP_REQ plus 1 cycle to DONE. A two-byte fetch takes 3 cycles. Each wait cycle adds 1.

Decomposition:
- Shared package byteblast_pkg holds:
  - ADDR_W/DATA_W defaults
  - OPERAND_BIT
  - the ifetch state enum {IDLE, OP_REQ, ARG_REQ, DONE}
- One sub-module, pc_8bit: an async-reset register with load (jump) and increment (wrap) controls.
- FSM, IR registers and handshake logic stay in ifetch_8bit.

Test Plan:
- Reset with fetch=1: assert rst_n=0 mid-cycle -> immediately pc=0x00, mem_req=0, ir_valid=0, fde_enable=0. Release -> OP_REQ on the next edge.
- One-byte fetch: mem[0x00]=0x12, ack 2 cycles after req -> mem_addr=0x00 for 3 cycles, then ir_opcode=0x12, ir_operand unchanged (0x00), pc=0x01, ir_valid=1, fde_enable=1 in DONE.
- Two-byte fetch: mem[0x01]=0x85, mem[0x02]=0x3C, zero-wait ack -> reads at 0x01 then 0x02 back-to-back, ir_opcode=0x85, ir_operand=0x3C, pc=0x03.
- Jump: execute=1, jump_en=1, jump_addr=0x40 -> pc=0x40, next fetch reads 0x40. Repeat with execute=0 -> pc unchanged.
- Wrap: pc=0xFF, mem[0xFF]=0x90, mem[0x00]=0x07 -> reads 0xFF then 0x00, operand=0x07, pc=0x01.
- Reset mid-wait: rst_n=0 while in ARG_REQ awaiting ack -> mem_req=0 at once, pc=RESET_PC. An ack pulse after release -> no IR change, ir_valid=0.
